// File: rtl/calc_key_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | calc_key_conditioner                                                       |
// | Synchronises and debounces KEY[3:0]/Mode, emits one-cycle command pulses.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module calc_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [3:0] KEY,
  input  logic       Mode,
  output logic       Clear,
  output logic       Equals,
  output logic       Add,
  output logic       Subtract,
  output logic       Multiply,
  output logic       Divide,
  output logic       KeyHeld
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Pulse vector layout: {Clear, Equals, Add, Subtract, Multiply, Divide}
  localparam logic [5:0] c_p_clr = 6'b100000;
  localparam logic [5:0] c_p_equ = 6'b010000;
  localparam logic [5:0] c_p_add = 6'b001000;
  localparam logic [5:0] c_p_sub = 6'b000100;
  localparam logic [5:0] c_p_mul = 6'b000010;
  localparam logic [5:0] c_p_div = 6'b000001;

  logic [3:0] r_key_meta;
  logic [3:0] r_key_sync;
  logic       r_mode_meta;
  logic       r_mode_sync;
  logic [3:0] w_stable;
  logic [3:0] r_stable_q;
  logic [3:0] w_press;
  logic [5:0] w_pulse_next;
  logic [5:0] r_pulse;
  logic       r_key_held;

  // Two-flop synchronisers; keys idle released (1), mode idles 0
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_key_meta  <= 4'b1111;
      r_key_sync  <= 4'b1111;
      r_mode_meta <= 1'b0;
      r_mode_sync <= 1'b0;
    end else begin
      r_key_meta  <= KEY;
      r_key_sync  <= r_key_meta;
      r_mode_meta <= Mode;
      r_mode_sync <= r_mode_meta;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_debounce
      logic [CNT_W-1:0] r_cnt;
      logic             r_stable;

      // Any return to the accepted level restarts the stability count
      always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
          r_cnt    <= '0;
          r_stable <= 1'b1;
        end else if (r_key_sync[gi] == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
          r_stable <= r_key_sync[gi];
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_stable[gi] = r_stable;
    end
  endgenerate

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_stable_q <= 4'b1111;
    end else begin
      r_stable_q <= w_stable;
    end
  end

  assign w_press = r_stable_q & ~w_stable;

  // Lowest key index wins; lower-priority simultaneous presses are dropped
  always_comb begin
    w_pulse_next = 6'b000000;
    if (w_press[0]) begin
      w_pulse_next = r_mode_sync ? c_p_clr : c_p_div;
    end else if (w_press[1]) begin
      w_pulse_next = r_mode_sync ? 6'b000000 : c_p_mul;
    end else if (w_press[2]) begin
      w_pulse_next = r_mode_sync ? 6'b000000 : c_p_sub;
    end else if (w_press[3]) begin
      w_pulse_next = r_mode_sync ? c_p_equ : c_p_add;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pulse    <= 6'b000000;
      r_key_held <= 1'b0;
    end else begin
      r_pulse    <= w_pulse_next;
      r_key_held <= ~&w_stable;
    end
  end

  assign Clear    = r_pulse[5];
  assign Equals   = r_pulse[4];
  assign Add      = r_pulse[3];
  assign Subtract = r_pulse[2];
  assign Multiply = r_pulse[1];
  assign Divide   = r_pulse[0];
  assign KeyHeld  = r_key_held;

endmodule
`default_nettype wire

// File: tb/tb_calc_key_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_calc_key_conditioner                                                    |
// | Scoreboard bench for calc_key_conditioner with DEBOUNCE_CYCLES = 4.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_calc_key_conditioner;

  localparam int c_latency = 7;  // DEBOUNCE_CYCLES + 3
  localparam logic [5:0] c_p_clr = 6'b100000;
  localparam logic [5:0] c_p_equ = 6'b010000;
  localparam logic [5:0] c_p_add = 6'b001000;
  localparam logic [5:0] c_p_sub = 6'b000100;
  localparam logic [5:0] c_p_mul = 6'b000010;
  localparam logic [5:0] c_p_div = 6'b000001;

  logic       clk;
  logic       rst_n;
  logic [3:0] r_key;
  logic       r_mode;
  logic       w_clear, w_equals, w_add, w_sub, w_mul, w_div, w_held;
  logic [5:0] w_vec;

  int         n_vec;
  int         n_err;
  int         edge_cnt;
  int         q_cyc[$];
  logic [5:0] q_vec[$];

  calc_key_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) u_dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .KEY     (r_key),
    .Mode    (r_mode),
    .Clear   (w_clear),
    .Equals  (w_equals),
    .Add     (w_add),
    .Subtract(w_sub),
    .Multiply(w_mul),
    .Divide  (w_div),
    .KeyHeld (w_held)
  );

  assign w_vec = {w_clear, w_equals, w_add, w_sub, w_mul, w_div};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input logic [5:0] v);
    q_cyc.push_back(edge_cnt + c_latency);
    q_vec.push_back(v);
  endtask

  // Every nonzero output must match the head of the scoreboard, at its cycle
  always @(negedge clk) begin
    if (w_vec != 6'b000000) begin
      check("onehot", 32'($countones(w_vec)), 32'd1);
      if (q_cyc.size() == 0) begin
        check("spurious", 32'(w_vec), 32'd0);
      end else begin
        check("pulse_cycle", 32'(edge_cnt), 32'(q_cyc.pop_front()));
        check("pulse_kind", 32'(w_vec), 32'(q_vec.pop_front()));
      end
    end
  end

  // Press one key with the given mode, hold, release and let the release settle
  task automatic press(input logic [3:0] k, input logic [5:0] v, input bit emits);
    r_key = k;
    if (emits) expect_pulse(v);
    tick(c_latency);
    check("held_on_press", 32'(w_held), 32'd1);
    tick(5);
    r_key = 4'b1111;
    tick(12);
    check("held_after_release", 32'(w_held), 32'd0);
  endtask

  int e;

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    r_key  = 4'b1111;
    r_mode = 1'b0;

    // 1: reset state holds
    tick(1);
    check("reset_pulses", 32'(w_vec), 32'd0);
    check("reset_held", 32'(w_held), 32'd0);
    tick(10);
    check("reset_pulses_10", 32'(w_vec), 32'd0);
    check("reset_held_10", 32'(w_held), 32'd0);
    rst_n = 1'b1;
    tick(4);

    // 2: clean Add press, KeyHeld timing on press and release
    e = edge_cnt;
    r_key = 4'b0111;
    expect_pulse(c_p_add);
    tick(c_latency - 1);
    check("add_held_early", 32'(w_held), 32'd0);
    tick(1);
    check("add_held_on", 32'(w_held), 32'd1);
    tick(20 - c_latency);
    e = edge_cnt;
    r_key = 4'b1111;
    tick(c_latency - 1);
    check("add_held_before_rel", 32'(w_held), 32'd1);
    tick(1);
    check("add_held_off", 32'(w_held), 32'd0);
    tick(4);

    // 3: bouncing KEY[2] then settled low
    for (int i = 0; i < 8; i++) begin
      r_key = (i % 2 == 0) ? 4'b1011 : 4'b1111;
      tick(1);
    end
    press(4'b1011, c_p_sub, 1'b1);

    // 4: mode 1 commands; KEY[1] is accepted but silent
    r_mode = 1'b1;
    tick(3);
    press(4'b1110, c_p_clr, 1'b1);
    press(4'b0111, c_p_equ, 1'b1);
    press(4'b1101, 6'b000000, 1'b0);

    // 5: simultaneous KEY[0]/KEY[1], only Divide survives
    r_mode = 1'b0;
    tick(3);
    press(4'b1100, c_p_div, 1'b1);

    // 6: reset mid-debounce with KEY[1] held
    r_key = 4'b1101;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    check("rst_mid_held", 32'(w_held), 32'd0);
    tick(3);
    check("rst_mid_pulses", 32'(w_vec), 32'd0);
    rst_n = 1'b1;
    expect_pulse(c_p_mul);
    tick(c_latency);
    check("rst_held_on", 32'(w_held), 32'd1);
    tick(3);
    r_key = 4'b1111;
    tick(12);

    check("scoreboard_empty", 32'(q_cyc.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
